// File: rtl/apb_pkg.sv
// Shared APB definitions for the register-table write path (master and slave side).
package apb_pkg;

  // APB master phase encoding
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // Register-table bus widths, shared with the write slave
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority rotates to the index after the last winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic          found;

  // Scan requesters starting at ptr and grant the first one pending
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + off) % N))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          win_idx  = PW'(i);
        end
      end
    end
  end

  // Move priority past the winner only when a grant is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_write_sequencer.sv
// APB write master: round-robin requester arbitration, SETUP/ACCESS sequencing and wait-state timeout.
module apb_write_sequencer
  import apb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  apb_state_t         state;
  apb_state_t         state_nxt;
  logic [NUM_REQ-1:0] owner;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] arb_req;
  logic [CNT_W-1:0]   wait_cnt;
  logic               arb_en;
  logic               start;
  logic               complete;
  logic               timeout_hit;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk  (PCLK),
    .rst  (PRESET),
    .req  (arb_req),
    .en   (arb_en),
    .grant(grant)
  );

  // Next-state logic; a timeout always returns to IDLE so the bus visibly drops before the next write
  always_comb begin
    state_nxt   = state;
    arb_en      = 1'b0;
    arb_req     = req_valid;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      APB_IDLE: begin
        arb_en = 1'b1;
        if (|req_valid) state_nxt = APB_SETUP;
      end
      APB_SETUP: begin
        state_nxt = APB_ACCESS;
      end
      APB_ACCESS: begin
        timeout_hit = !PREADY && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
        complete    = PREADY || timeout_hit;
        if (timeout_hit) begin
          state_nxt = APB_IDLE;
        end else if (PREADY) begin
          arb_en    = 1'b1;
          arb_req   = req_valid & ~owner;
          state_nxt = (|arb_req) ? APB_SETUP : APB_IDLE;
        end
      end
      default: begin
        state_nxt = APB_IDLE;
      end
    endcase
  end

  assign start = arb_en && (|grant);

  // Select the granted requester's address and data slice
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Phase register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= APB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture registers, ack/done/err pulses and the wait-state counter
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PADDR    <= '0;
      PWDATA   <= '0;
      owner    <= '0;
      wait_cnt <= '0;
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= '0;
    end else begin
      req_ack  <= start ? grant : '0;
      req_done <= complete ? owner : '0;
      req_err  <= (complete && (timeout_hit || PSLVERR)) ? owner : '0;
      if (start) begin
        PADDR    <= win_addr;
        PWDATA   <= win_data;
        owner    <= grant;
        wait_cnt <= '0;
      end else if ((state == APB_ACCESS) && !PREADY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign PSEL    = (state != APB_IDLE);
  assign PENABLE = (state == APB_ACCESS);
  assign PWRITE  = PSEL;
  assign busy    = (state != APB_IDLE);

endmodule
